// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: merges per-stage stall requests
// with the MEM-stage exception/ERET redirect, plus a stall-cycle counter and watchdog.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_request_if,
  input  logic        stall_request_id,
  input  logic        stall_request_ex,
  input  logic        stall_request_mem,
  input  logic        exc_req,
  input  logic [31:0] exc_target,
  output logic        stall_pc,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        stall_wb,
  output logic        flush,
  output logic        pc_redirect_en,
  output logic [31:0] pc_redirect_addr,
  output logic [31:0] stall_cycle_count,
  output logic        stall_timeout
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE   = TIMEOUT_WIDTH'(1);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_W-1:0]        pend_target;
  logic                     latch_target;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  logic                     casc_ex;
  logic                     casc_id;
  logic                     casc_if;

  // Oldest requesting stage holds itself and every younger stage behind it
  assign casc_ex = stall_request_mem | stall_request_ex;
  assign casc_id = casc_ex | stall_request_id;
  assign casc_if = casc_id | stall_request_if;

  // Next state and same-cycle pipeline controls
  always_comb begin
    state_nxt        = state;
    latch_target     = 1'b0;
    stall_pc         = 1'b0;
    stall_if         = 1'b0;
    stall_id         = 1'b0;
    stall_ex         = 1'b0;
    stall_mem        = 1'b0;
    stall_wb         = 1'b0;
    flush            = 1'b0;
    pc_redirect_en   = 1'b0;
    pc_redirect_addr = '0;
    unique case (state)
      RUN: begin
        if (exc_req) begin
          if (stall_request_if) begin
            // Fetch cannot be abandoned: bubble MEMWB and park the redirect
            {stall_pc, stall_if, stall_id, stall_ex, stall_mem} = 5'b11111;
            latch_target = 1'b1;
            state_nxt    = PEND;
          end else begin
            flush            = 1'b1;
            pc_redirect_en   = 1'b1;
            pc_redirect_addr = exc_target;
          end
        end else begin
          stall_mem = stall_request_mem;
          stall_ex  = casc_ex;
          stall_id  = casc_id;
          stall_if  = casc_if;
          stall_pc  = casc_if;
        end
      end
      PEND: begin
        if (stall_request_if) begin
          {stall_pc, stall_if, stall_id, stall_ex, stall_mem} = 5'b11111;
        end else begin
          flush            = 1'b1;
          pc_redirect_en   = 1'b1;
          pc_redirect_addr = pend_target;
          state_nxt        = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pend_target <= '0;
    end else begin
      state <= state_nxt;
      if (latch_target) pend_target <= exc_target;
    end
  end

  // Performance counter: stalled cycles that are not flush cycles, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycle_count <= '0;
    end else if (stall_pc && !flush) begin
      stall_cycle_count <= stall_cycle_count + CNT_W'(1);
    end
  end

  // Watchdog: consecutive stalled cycles, saturating; timeout is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (!stall_pc) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + WD_ONE;
      end
      if (stall_pc && (wd_cnt == WD_LIMIT - WD_ONE)) stall_timeout <= 1'b1;
    end
  end

endmodule
